router_output_unit: RTL

- Output-side stage of the 5-port router; one instance per output port.
- Directly consumes the request, {valid,flit} buses and handshakes produced by the five input datapaths.
- Arbitrates among the five input ports with round-robin priority and locks the port to the winner for a whole packet.
- Buffers accepted flits in a small FIFO and drives them onto the output link with a valid/ready handshake.

---
 rtl/router_output_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/router_output_unit.sv
// Output-side stage of the 5-port router: round-robin packet arbitration with
// per-packet port locking, followed by a small FIFO feeding the output link.
module router_output_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       req,
  input  logic [WIDTH:0]   in0,
  input  logic [WIDTH:0]   in1,
  input  logic [WIDTH:0]   in2,
  input  logic [WIDTH:0]   in3,
  input  logic [WIDTH:0]   in4,
  output logic [4:0]       grant,
  output logic             available,
  output logic             ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NP        = 5;
  localparam logic [1:0]  TYPE_TAIL = 2'b01;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_next;
  logic [2:0]       owner, owner_next;
  logic [2:0]       ptr, ptr_next;
  logic [NP-1:0]    grant_next;
  logic             available_next;

  logic [WIDTH:0]   in_bus [NP];
  logic [WIDTH:0]   owner_in;
  logic             found;
  logic [2:0]       winner;
  logic [3:0]       cand;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             wr_en, rd_en, tail_wr;

  assign in_bus[0] = in0;
  assign in_bus[1] = in1;
  assign in_bus[2] = in2;
  assign in_bus[3] = in3;
  assign in_bus[4] = in4;

  // Round-robin search: first requester at or above ptr, wrapping mod 5.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = '0;
    for (int k = 0; k < NP; k++) begin
      cand = 4'(ptr) + 4'(k);
      if (cand >= 4'(NP)) cand = cand - 4'(NP);
      if (!found && req[cand[2:0]]) begin
        found  = 1'b1;
        winner = cand[2:0];
      end
    end
  end

  assign owner_in  = in_bus[owner];
  assign ready     = (count != (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign wr_en     = (state == LOCKED) && owner_in[WIDTH] && ready;
  assign tail_wr   = wr_en && (owner_in[WIDTH-1 -: 2] == TYPE_TAIL);
  assign rd_en     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      grant     <= '0;
      available <= 1'b1;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      ptr       <= ptr_next;
      grant     <= grant_next;
      available <= available_next;
    end
  end

  always_comb begin
    state_next     = state;
    owner_next     = owner;
    ptr_next       = ptr;
    grant_next     = '0;
    available_next = 1'b1;
    case (state)
      IDLE: begin
        if (found) begin
          state_next         = LOCKED;
          owner_next         = winner;
          grant_next[winner] = 1'b1;
          available_next     = 1'b0;
        end
      end
      LOCKED: begin
        grant_next[owner] = 1'b1;
        available_next    = 1'b0;
        // Tail write frees the port; the next search starts just past the owner.
        if (tail_wr) begin
          state_next     = IDLE;
          grant_next     = '0;
          available_next = 1'b1;
          ptr_next       = (owner == 3'(NP - 1)) ? 3'd0 : owner + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; out_data is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= owner_in[WIDTH-1:0];
  end

endmodule
